seq_magnitude_comparator: RTL and testbench

//  Parametrised multi-cycle magnitude comparator, successor to the fixed 4-bit combinational comparator.

---
 rtl/seq_magnitude_comparator.sv | 113 +++++++++++
 tb/tb_seq_magnitude_comparator.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: CHUNK bits per cycle, MSB chunk first, early exit on difference.
// Optional SEQ_CMP_SIGNED_EN: two's-complement compare via MSB inversion in the first chunk.
module seq_magnitude_comparator #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             less,
   output logic             equal,
   output logic             greater
);

   localparam int unsigned NumChunks = WIDTH / CHUNK;
   localparam int unsigned CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(NumChunks - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             less_q, less_d, equal_q, equal_d, greater_q, greater_d;
   logic [CHUNK-1:0] slice_a, slice_b, cmp_a, cmp_b;

   assign slice_a = sa_q[WIDTH-1 -: CHUNK];
   assign slice_b = sb_q[WIDTH-1 -: CHUNK];

`ifdef SEQ_CMP_SIGNED_EN
   localparam logic [CHUNK-1:0] MsbMask = CHUNK'(1) << (CHUNK - 1);
   logic first_chunk;

   // Counter still holds its load value only while the MSB chunk is on top.
   assign first_chunk = (cnt_q == LastCnt);
   assign cmp_a = slice_a ^ (first_chunk ? MsbMask : '0);
   assign cmp_b = slice_b ^ (first_chunk ? MsbMask : '0);
`else
   assign cmp_a = slice_a;
   assign cmp_b = slice_b;
`endif

   always_comb begin
      state_d   = state_q;
      sa_d      = sa_q;
      sb_d      = sb_q;
      cnt_d     = cnt_q;
      less_d    = less_q;
      equal_d   = equal_q;
      greater_d = greater_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d   = StRun;
               sa_d      = A;
               sb_d      = B;
               cnt_d     = LastCnt;
               less_d    = 1'b0;
               equal_d   = 1'b0;
               greater_d = 1'b0;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            if (cmp_a != cmp_b) begin
               less_d    = (cmp_a < cmp_b);
               greater_d = (cmp_a > cmp_b);
               state_d   = StDone;
            end else if (cnt_q == '0) begin
               equal_d = 1'b1;
               state_d = StDone;
            end else begin
               sa_d  = sa_q << CHUNK;
               sb_d  = sb_q << CHUNK;
               cnt_d = cnt_q - CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         sa_q      <= '0;
         sb_q      <= '0;
         cnt_q     <= '0;
         less_q    <= 1'b0;
         equal_q   <= 1'b0;
         greater_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sa_q      <= sa_d;
         sb_q      <= sb_d;
         cnt_q     <= cnt_d;
         less_q    <= less_d;
         equal_q   <= equal_d;
         greater_q <= greater_d;
      end
   end

   assign busy    = (state_q == StRun);
   assign done    = (state_q == StDone);
   assign less    = less_q;
   assign equal   = equal_q;
   assign greater = greater_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator: arithmetic reference model checked every cycle plus
// directed scenarios with hand-computed latencies and flags.
module tb_seq_magnitude_comparator;

   localparam int unsigned W = 16;
   localparam int unsigned C = 4;
   localparam int unsigned N = W / C;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         busy, done, less, equal, greater;

   int checks = 0;
   int errors = 0;

   seq_magnitude_comparator #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
      .busy(busy), .done(done), .less(less), .equal(equal), .greater(greater)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference result {less, equal, greater} straight from arithmetic.
   function automatic logic [2:0] ref_flags(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SEQ_CMP_SIGNED_EN
      if ($signed(a) < $signed(b)) return 3'b100;
      if ($signed(a) > $signed(b)) return 3'b001;
`else
      if (a < b) return 3'b100;
      if (a > b) return 3'b001;
`endif
      return 3'b010;
   endfunction

   // RUN cycles needed: index of the chunk holding the highest differing bit.
   function automatic int ref_cycles(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] x;
      int p;
      x = a ^ b;
      if (x == '0) return N;
      p = 0;
      for (int i = 0; i < W; i++) if (x[i]) p = i;
      return (W - 1 - p) / C + 1;
   endfunction

   logic       m_busy, m_done;
   logic [2:0] m_flags, m_res;
   int         m_rem;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy  <= 1'b0;
         m_done  <= 1'b0;
         m_flags <= 3'b000;
         m_res   <= 3'b000;
         m_rem   <= 0;
      end else if (!m_busy && start) begin
         m_busy  <= 1'b1;
         m_done  <= 1'b0;
         m_flags <= 3'b000;
         m_res   <= ref_flags(A, B);
         m_rem   <= ref_cycles(A, B);
      end else if (m_busy) begin
         if (m_rem == 1) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b1;
            m_flags <= m_res;
         end else begin
            m_rem <= m_rem - 1;
         end
      end else begin
         m_done <= 1'b0;
      end
   end

   always @(negedge clk) begin
      check("model", {27'd0, busy, done, less, equal, greater},
            {27'd0, m_busy, m_done, m_flags});
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
      A = a;
      B = b;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Edges from the current point until done; busy_cycles counts busy samples on the way.
   task automatic wait_done(output int edges, output int busy_cycles);
      edges = 0;
      busy_cycles = 0;
      while (!done && edges < 40) begin
         if (busy) busy_cycles++;
         step();
         edges++;
      end
      check("done_seen", {31'd0, done}, 32'd1);
   endtask

   int e, bc, dcnt;

   initial begin
      step();
      step();
      check("reset_outs", {27'd0, busy, done, less, equal, greater}, 32'd0);
      rst = 1'b0;
      step();

      // 1: asynchronous reset mid-RUN
      accept(16'h1234, 16'h1235);
      step();
      check("t1_busy", {31'd0, busy}, 32'd1);
      #2 rst = 1'b1;
      #1 check("t1_async", {27'd0, busy, done, less, equal, greater}, 32'd0);
      #3 rst = 1'b0;
      dcnt = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (done || busy) dcnt++;
      end
      check("t1_no_done", dcnt, 32'd0);

      // 2: resolves in chunk 1 (edge counts below include the accept edge)
      accept(16'h3000, 16'h4FFF);
      wait_done(e, bc);
      check("t2_edges", e + 1, 32'd2);
      check("t2_flags", {29'd0, less, equal, greater}, 32'b100);
      step();

      // 3: equal operands, worst case
      accept(16'hBEEF, 16'hBEEF);
      wait_done(e, bc);
      check("t3_edges", e + 1, 32'd5);
      check("t3_busy", bc, 32'd4);
      check("t3_flags", {29'd0, less, equal, greater}, 32'b010);
      step();
      check("t3_hold", {29'd0, less, equal, greater}, 32'b010);

      // 4: last-chunk difference, then back-to-back accept from DONE
      accept(16'h1239, 16'h1238);
      wait_done(e, bc);
      check("t4_edges", e + 1, 32'd5);
      check("t4_flags", {29'd0, less, equal, greater}, 32'b001);
      accept(16'h0001, 16'h0002);
      check("t4_clear", {28'd0, busy, less, equal, greater}, 32'b1000);
      wait_done(e, bc);
      check("t4b_edges", e + 1, 32'd5);
      check("t4b_flags", {29'd0, less, equal, greater}, 32'b100);
      step();

      // 5: start during busy with new operands is ignored
      accept(16'h1200, 16'h1300);
      A = 16'hFFFF;
      B = 16'h0000;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done(e, bc);
      check("t5_edges", e + 2, 32'd3);
      check("t5_flags", {29'd0, less, equal, greater}, 32'b100);
      step();

      // 6: -1 vs 1, signed vs unsigned build
      accept(16'hFFFF, 16'h0001);
      wait_done(e, bc);
      check("t6_edges", e + 1, 32'd2);
`ifdef SEQ_CMP_SIGNED_EN
      check("t6_flags", {29'd0, less, equal, greater}, 32'b100);
`else
      check("t6_flags", {29'd0, less, equal, greater}, 32'b001);
`endif
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
